// File: rtl/fpu_req_arbiter.sv
// Round-robin arbiter that shares one fixed-latency FPU core among NUM_REQ requesters.
// One operation is in flight at a time; the result is returned over a per-requester valid/ready handshake.
module fpu_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 3
) (
    input  logic                   Clk,
    input  logic                   RstN,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    input  logic [4*NUM_REQ-1:0]   req_op,
    output logic [31:0]            a_operand,
    output logic [31:0]            b_operand,
    output logic [3:0]             Operation,
    input  logic [31:0]            FPU_Output,
    input  logic                   Exception,
    input  logic                   Overflow,
    input  logic                   Underflow,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [31:0]            rsp_data,
    output logic [2:0]             rsp_flags,
    output logic                   busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(LATENCY + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] grant;
    logic [IW-1:0] pick;
    logic          found;
    logic [CW-1:0] counter;

    logic [31:0] a_arr  [NUM_REQ];
    logic [31:0] b_arr  [NUM_REQ];
    logic [3:0]  op_arr [NUM_REQ];

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            a_arr[i]  = req_a[32*i +: 32];
            b_arr[i]  = req_b[32*i +: 32];
            op_arr[i] = req_op[4*i +: 4];
        end
    end

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned   idx;
        logic [IW-1:0] cand;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = IW'(idx);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (RstN && state == IDLE && found) begin
            req_ready[pick] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state == RESP) begin
            rsp_valid[grant] = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge Clk) begin
        if (!RstN) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            counter   <= '0;
            a_operand <= '0;
            b_operand <= '0;
            Operation <= '0;
            rsp_data  <= '0;
            rsp_flags <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        a_operand <= a_arr[pick];
                        b_operand <= b_arr[pick];
                        Operation <= op_arr[pick];
                        grant     <= pick;
                        counter   <= CW'(LATENCY);
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    counter <= counter - 1'b1;
                    if (counter == CW'(1)) begin
                        rsp_data  <= FPU_Output;
                        rsp_flags <= {Exception, Overflow, Underflow};
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready[grant]) begin
                        // Pointer moves past the served requester so it queues behind everyone else.
                        rr_ptr <= (32'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Directed bench for fpu_req_arbiter: stub FPU core, transaction-level model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_fpu_req_arbiter;

    localparam int N   = 4;
    localparam int LAT = 3;

    logic              Clk = 1'b0;
    logic              RstN;
    logic [N-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
    logic [32*N-1:0]   req_a, req_b;
    logic [4*N-1:0]    req_op;
    logic [31:0]       a_operand, b_operand, FPU_Output, rsp_data;
    logic [3:0]        Operation;
    logic              Exception, Overflow, Underflow, busy;
    logic [2:0]        rsp_flags;

    logic [31:0] ta [N];
    logic [31:0] tbv [N];
    logic [3:0]  top [N];
    logic        noise;
    logic        auto_drop;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    always #5 Clk = ~Clk;

    fpu_req_arbiter #(.NUM_REQ(N), .LATENCY(LAT)) dut (
        .Clk(Clk), .RstN(RstN),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .a_operand(a_operand), .b_operand(b_operand), .Operation(Operation),
        .FPU_Output(FPU_Output), .Exception(Exception), .Overflow(Overflow), .Underflow(Underflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .busy(busy)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = ta[i];
            req_b[32*i +: 32] = tbv[i];
            req_op[4*i +: 4]  = top[i];
        end
    end

    // Positive-normal single-precision add, truncating; enough for the stub core.
    function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] hi, lo;
        logic [7:0]  e;
        logic [23:0] mh, ml;
        logic [24:0] s;
        int unsigned d;
        if (x[30:23] < y[30:23]) begin hi = y; lo = x; end
        else begin hi = x; lo = y; end
        e  = hi[30:23];
        mh = {1'b1, hi[22:0]};
        ml = {1'b1, lo[22:0]};
        d  = 32'(hi[30:23]) - 32'(lo[30:23]);
        ml = (d > 23) ? 24'd0 : (ml >> d);
        s  = {1'b0, mh} + {1'b0, ml};
        if (s[24]) return {hi[31], e + 8'd1, s[23:1]};
        return {hi[31], e, s[22:0]};
    endfunction

    function automatic logic [34:0] core_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'h0:    return {3'b000, fadd(a, b)};
            4'h2:    return {3'b001, a - b};
            4'hF:    return {3'b110, 32'h7F80_0000};
            default: return {3'b000, a ^ b};
        endcase
    endfunction

    // Stub core: result appears LAT cycles after the operands change.
    logic [34:0] pipe [LAT-1];
    always @(posedge Clk) begin
        pipe[0] <= core_fn(a_operand, b_operand, Operation);
        for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign FPU_Output = pipe[LAT-2][31:0] ^ {32{noise}};
    assign {Exception, Overflow, Underflow} = pipe[LAT-2][34:32] ^ {3{noise}};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: one in-flight op, aged in cycles since acceptance.
    bit          m_ok = 0;
    bit          m_act = 0;
    int          m_rr = 0, m_g = 0, m_age = 0;
    logic [31:0] m_a = '0, m_b = '0, m_data = '0;
    logic [3:0]  m_op = '0;
    logic [2:0]  m_flags = '0;
    int          gq_idx [$];
    int          gq_cyc [$];

    always @(negedge Clk) begin
        logic [N-1:0] e_rr, e_rv;
        logic [34:0]  r;
        int           j, pk;
        bit           fnd;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin gq_idx.push_back(i); gq_cyc.push_back(cyc); end
        end
        e_rr = '0; e_rv = '0; fnd = 0; pk = 0; j = 0;
        if (RstN && !m_act) begin
            for (int k = 0; k < N; k++) begin
                j = (m_rr + k) % N;
                if (!fnd && req_valid[j]) begin fnd = 1; pk = j; e_rr[j] = 1'b1; end
            end
        end
        if (m_act && m_age > LAT) e_rv[m_g] = 1'b1;
        if (m_ok) begin
            check("req_ready", 32'(req_ready), 32'(e_rr));
            check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
            check("busy", 32'(busy), 32'(m_act));
            check("rsp_data", rsp_data, m_data);
            check("rsp_flags", 32'(rsp_flags), 32'(m_flags));
            check("a_operand", a_operand, m_a);
            check("b_operand", b_operand, m_b);
            check("Operation", 32'(Operation), 32'(m_op));
        end
        if (!RstN) begin
            m_ok = 1; m_act = 0; m_rr = 0;
            m_a = '0; m_b = '0; m_op = '0; m_data = '0; m_flags = '0;
        end else if (!m_act) begin
            if (fnd) begin
                m_act = 1; m_g = pk; m_age = 1;
                m_a = ta[pk]; m_b = tbv[pk]; m_op = top[pk];
            end
        end else begin
            if (m_age == LAT) begin
                r = core_fn(m_a, m_b, m_op);
                m_data = r[31:0]; m_flags = r[34:32];
            end
            if (m_age > LAT && rsp_ready[m_g]) begin
                m_act = 0; m_rr = (m_g + 1) % N;
            end
            m_age++;
        end
    end

    logic [N-1:0] s_rr, s_rv;
    logic [31:0]  s_data, s_a;
    logic [2:0]   s_flags;
    logic         s_busy;

    task automatic tick();
        @(negedge Clk);
        s_rr = req_ready; s_rv = rsp_valid; s_data = rsp_data;
        s_flags = rsp_flags; s_busy = busy; s_a = a_operand;
        @(posedge Clk);
        #1;
        if (auto_drop) req_valid = req_valid & ~s_rr;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        ta[i] = a; tbv[i] = b; top[i] = op; req_valid[i] = 1'b1;
    endtask

    task automatic wait_grant(input string name, input int i);
        int n = 0;
        do begin tick(); n++; end while (s_rr == '0 && n < 30);
        check(name, 32'(s_rr), 32'(1) << i);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin tick(); n++; end while (s_rv == '0 && n < 30);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin tick(); n++; end while ((s_busy || req_valid != '0) && n < 100);
        check(name, 32'(n < 100), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int exp_order [5] = '{0, 1, 2, 3, 0};
        RstN = 1'b0; req_valid = '0; rsp_ready = '0; noise = 1'b0; auto_drop = 1'b1;
        for (int i = 0; i < N; i++) begin ta[i] = '0; tbv[i] = '0; top[i] = '0; end
        repeat (3) tick();
        RstN = 1'b1;
        tick();
        check("reset_busy", 32'(s_busy), 32'd0);
        check("reset_rsp_valid", 32'(s_rv), 32'd0);
        check("reset_rsp_data", s_data, 32'd0);

        // 1.0 + 2.0 on requester 0
        set_req(0, 32'h3F80_0000, 32'h4000_0000, 4'h0);
        wait_grant("t1_grant", 0);
        wait_rsp(n);
        check("t1_latency", 32'(n), 32'd4);
        check("t1_rsp_valid", 32'(s_rv), 32'b0001);
        check("t1_rsp_data", s_data, 32'h4040_0000);
        check("t1_rsp_flags", 32'(s_flags), 32'd0);
        rsp_ready = '1;
        tick();
        tick();
        check("t1_idle_after", 32'(s_busy), 32'd0);

        // All requesters held valid from reset: fair rotation, fixed spacing
        RstN = 1'b0; auto_drop = 1'b0; req_valid = '1;
        for (int i = 0; i < N; i++) begin ta[i] = 32'h100 * (i + 1); tbv[i] = 32'h3 + i; top[i] = 4'h1; end
        tick(); tick();
        gq_idx.delete(); gq_cyc.delete();
        RstN = 1'b1;
        repeat (27) tick();
        req_valid = '0; auto_drop = 1'b1;
        wait_idle("t2_drain");
        check("t2_grant_count", 32'(gq_idx.size() >= 5), 32'd1);
        for (int i = 0; i < 5 && i < gq_idx.size(); i++) begin
            check("t2_order", 32'(gq_idx[i]), 32'(exp_order[i]));
            if (i > 0) check("t2_spacing", 32'(gq_cyc[i] - gq_cyc[i-1]), 32'd5);
        end

        // Requester 1 stalls its response while requester 2 waits
        rsp_ready = '0;
        set_req(1, 32'h1234_5678, 32'h0F0F_0F0F, 4'h1);
        wait_grant("t3_grant1", 1);
        set_req(2, 32'h0000_0005, 32'h0000_0003, 4'h2);
        wait_rsp(n);
        check("t3_rsp_valid", 32'(s_rv), 32'b0010);
        check("t3_rsp_data", s_data, 32'h1D3B_5977);
        noise = 1'b1;
        repeat (5) begin
            tick();
            check("t3_hold_valid", 32'(s_rv), 32'b0010);
            check("t3_hold_data", s_data, 32'h1D3B_5977);
            check("t3_no_grant", 32'(s_rr), 32'd0);
        end
        noise = 1'b0;
        rsp_ready = 4'b0010;
        tick();
        tick();
        check("t3_grant2", 32'(s_rr), 32'b0100);
        rsp_ready = '1;
        wait_idle("t3_drain");

        // rr_ptr now 3: requester 3 goes before requester 0
        set_req(0, 32'h0000_00AA, 32'h0000_0055, 4'h1);
        set_req(3, 32'h0000_0011, 32'h0000_0022, 4'h2);
        wait_grant("t6_first", 3);
        wait_grant("t6_second", 0);
        wait_idle("t6_drain");

        // Flag capture and hold
        rsp_ready = '0;
        set_req(1, 32'h0, 32'h0, 4'hF);
        wait_grant("t4_grant", 1);
        wait_rsp(n);
        check("t4_rsp_data", s_data, 32'h7F80_0000);
        check("t4_rsp_flags", 32'(s_flags), 32'b110);
        noise = 1'b1;
        repeat (3) begin
            tick();
            check("t4_hold_flags", 32'(s_flags), 32'b110);
        end
        noise = 1'b0;
        rsp_ready = '1;
        wait_idle("t4_drain");

        // Reset during the second busy cycle of a requester-3 operation
        set_req(3, 32'h1, 32'h2, 4'h1);
        wait_grant("t5_grant3", 3);
        tick();
        RstN = 1'b0;
        set_req(3, 32'h1, 32'h2, 4'h1);
        set_req(1, 32'h7, 32'h9, 4'h1);
        tick();
        check("t5_ready_in_reset", 32'(s_rr), 32'd0);
        RstN = 1'b1;
        tick();
        check("t5_busy", 32'(s_busy), 32'd0);
        check("t5_rsp_valid", 32'(s_rv), 32'd0);
        check("t5_rsp_data", s_data, 32'd0);
        check("t5_a_operand", s_a, 32'd0);
        check("t5_grant1", 32'(s_rr), 32'b0010);
        wait_idle("t5_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
